// File: rtl/regfile_2r1w_clr_if.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_clr_if
// Bus bundle for the 2-read/1-write register file with sequential clear.
//
// Handshake semantics:
//   Writes are fire-and-forget strobes. A write is accepted only when wr_en=1,
//   the file is not busy and wr_addr is in range. A rejected write is reported
//   by a one-cycle err pulse on the following cycle. clr_req is a level that is
//   sampled only while idle. busy stays high for the whole clear sweep, and
//   clr_done pulses once in the first idle cycle after the sweep. All slave
//   outputs are registered.
//
// Signals (master = requester, slave = register file):
//   wr_en, wr_addr, wr_data, wr_perr_inj  : write port            (master -> slave)
//   rd_addr_a, rd_addr_b                  : read addresses        (master -> slave)
//   rd_data_a, rd_data_b                  : read data, 1-cycle    (slave -> master)
//   rd_perr_a, rd_perr_b                  : parity error flags    (slave -> master)
//   clr_req                               : start clear           (master -> slave)
//   busy, clr_done, err                   : status                (slave -> master)
// -----------------------------------------------------------------------------
interface regfile_2r1w_clr_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_perr_inj;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [WIDTH-1:0]  rd_data_a;
   logic [WIDTH-1:0]  rd_data_b;
   logic              rd_perr_a;
   logic              rd_perr_b;
   logic              clr_req;
   logic              busy;
   logic              clr_done;
   logic              err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_perr_inj, rd_addr_a, rd_addr_b, clr_req,
      input  rd_data_a, rd_data_b, rd_perr_a, rd_perr_b, busy, clr_done, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_perr_inj, rd_addr_a, rd_addr_b, clr_req,
      output rd_data_a, rd_data_b, rd_perr_a, rd_perr_b, busy, clr_done, err
   );
endinterface

// File: rtl/regfile_2r1w_clr.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_clr
// Shared scratch/config register bank. It has one write port, two independent
// registered read ports with write-through bypass, out-of-range detection and
// a sequential clear engine.
//
// Parameters: WIDTH (data bits), DEPTH (entries, any value up to 2**ADDR_W),
//             ADDR_W (address bits)
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-low reset
//   bus  : regfile_2r1w_clr_if.slave (write, two reads, clear, status)
//
// Optional build macro: REGFILE_PARITY_EN
//   Defined   -> one even-parity bit per entry. rd_perr_x flags a mismatch.
//   Undefined -> no parity storage. rd_perr_x stays 0 and wr_perr_inj is ignored.
//
// The clear FSM state is directly visible: busy is the decoded state register
// (1 = CLEAR, 0 = IDLE).
// -----------------------------------------------------------------------------
module regfile_2r1w_clr #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input logic                clk,
   input logic                rst,
   regfile_2r1w_clr_if.slave  bus
);

   generate
      if ((2 ** ADDR_W) < DEPTH) begin : g_bad_cfg
         $error("regfile_2r1w_clr: 2**ADDR_W must be >= DEPTH");
      end
   endgenerate

   // One extra bit lets the range compare work when DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              done_q, done_d;

   logic [WIDTH-1:0]  mem [DEPTH];

   logic              wr_in_range, rd_in_range_a, rd_in_range_b;
   logic              wr_ok, err_d, err_q;
   logic              stored_perr_a, stored_perr_b;
   logic [WIDTH:0]    rd_d_a, rd_d_b;          // {perr, data}
   logic [WIDTH-1:0]  rd_q_a, rd_q_b;
   logic              perr_q_a, perr_q_b;

   assign wr_in_range   = {1'b0, bus.wr_addr}   < DEPTH_C;
   assign rd_in_range_a = {1'b0, bus.rd_addr_a} < DEPTH_C;
   assign rd_in_range_b = {1'b0, bus.rd_addr_b} < DEPTH_C;

   // Writes are only taken while idle, so they never race the clear sweep.
   assign wr_ok = bus.wr_en && (state_q == IDLE) && wr_in_range;

   // All error causes merge into one pulse.
   assign err_d = (bus.wr_en && (!wr_in_range || (state_q == CLEAR)))
                  || !rd_in_range_a || !rd_in_range_b;

   // ---------------- clear FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- storage ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state_q == CLEAR) begin
         mem[idx_q] <= '0;
      end else if (wr_ok) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

`ifdef REGFILE_PARITY_EN
   logic par [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
      end else if (state_q == CLEAR) begin
         par[idx_q] <= 1'b0;
      end else if (wr_ok) begin
         par[bus.wr_addr] <= (^bus.wr_data) ^ bus.wr_perr_inj;
      end
   end

   // These are only meaningful for in-range addresses. The read mux masks the rest.
   assign stored_perr_a = par[bus.rd_addr_a] ^ (^mem[bus.rd_addr_a]);
   assign stored_perr_b = par[bus.rd_addr_b] ^ (^mem[bus.rd_addr_b]);
`else
   logic unused_perr_inj;
   assign unused_perr_inj = bus.wr_perr_inj;
   assign stored_perr_a   = 1'b0;
   assign stored_perr_b   = 1'b0;
`endif

   // ---------------- read muxes ----------------
   // Priority: out of range, then the entry being cleared this cycle, then the
   // same-cycle write bypass, then the stored entry. Only the stored entry can
   // report a parity error.
   function automatic logic [WIDTH:0] read_sel(
      input logic             in_range,
      input logic             clr_hit,
      input logic             byp_hit,
      input logic [WIDTH-1:0] byp_data,
      input logic [WIDTH-1:0] stored,
      input logic             stored_perr
   );
      logic [WIDTH:0] r;
      r = '0;
      if (!in_range || clr_hit) r = '0;
      else if (byp_hit)         r = {1'b0, byp_data};
      else                      r = {stored_perr, stored};
      return r;
   endfunction

   always_comb begin
      rd_d_a = read_sel(rd_in_range_a,
                        (state_q == CLEAR) && (bus.rd_addr_a == idx_q),
                        wr_ok && (bus.wr_addr == bus.rd_addr_a),
                        bus.wr_data, mem[bus.rd_addr_a], stored_perr_a);
      rd_d_b = read_sel(rd_in_range_b,
                        (state_q == CLEAR) && (bus.rd_addr_b == idx_q),
                        wr_ok && (bus.wr_addr == bus.rd_addr_b),
                        bus.wr_data, mem[bus.rd_addr_b], stored_perr_b);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_q_a   <= '0;
         rd_q_b   <= '0;
         perr_q_a <= 1'b0;
         perr_q_b <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rd_q_a   <= rd_d_a[WIDTH-1:0];
         rd_q_b   <= rd_d_b[WIDTH-1:0];
         perr_q_a <= rd_d_a[WIDTH];
         perr_q_b <= rd_d_b[WIDTH];
         err_q    <= err_d;
      end
   end

   assign bus.rd_data_a = rd_q_a;
   assign bus.rd_data_b = rd_q_b;
   assign bus.rd_perr_a = perr_q_a;
   assign bus.rd_perr_b = perr_q_b;
   assign bus.busy      = (state_q == CLEAR);
   assign bus.clr_done  = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w_clr
// Directed plus random stimulus for regfile_2r1w_clr (DEPTH=12, ADDR_W=4, so
// addresses 12..15 are out of range). A reference model tracks entry contents,
// injected-parity flags and clear progress, and predicts every registered
// output one edge ahead.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w_clr;
   localparam int WIDTH  = 8;
   localparam int DEPTH  = 12;
   localparam int ADDR_W = 4;
`ifdef REGFILE_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_2r1w_clr_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   regfile_2r1w_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cycles = 0;
   int done_pulses = 0;

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] ref_mem [DEPTH];
   logic             ref_inj [DEPTH];
   bit               ref_busy = 1'b0;
   int               ref_pos  = 0;

   logic [WIDTH-1:0] exp_a, exp_b;
   logic             exp_pa, exp_pb, exp_err, exp_busy, exp_done;

   function automatic logic [WIDTH-1:0] ref_read(input logic [ADDR_W-1:0] a,
                                                 input logic wr_taken,
                                                 output logic pe);
      pe = 1'b0;
      if (int'(a) >= DEPTH) return '0;
      if (ref_busy && int'(a) == ref_pos) return '0;
      if (wr_taken && bus.wr_addr == a) return bus.wr_data;
      pe = PAR && ref_inj[a];
      return ref_mem[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic en, input int waddr, input logic [WIDTH-1:0] wdata,
                        input logic inj, input int ra, input int rb, input logic clr);
      bus.wr_en       = en;
      bus.wr_addr     = ADDR_W'(waddr);
      bus.wr_data     = wdata;
      bus.wr_perr_inj = inj;
      bus.rd_addr_a   = ADDR_W'(ra);
      bus.rd_addr_b   = ADDR_W'(rb);
      bus.clr_req     = clr;
   endtask

   task automatic idle();
      drive(1'b0, 0, '0, 1'b0, 0, 0, 1'b0);
   endtask

   // Predict, clock one edge, then compare every output.
   task automatic step();
      logic wr_taken;
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_inj[i] = 1'b0;
         end
         ref_busy = 1'b0;
         ref_pos  = 0;
         exp_a = '0; exp_b = '0; exp_pa = 1'b0; exp_pb = 1'b0;
         exp_err = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
      end else begin
         wr_taken = bus.wr_en && !ref_busy && (int'(bus.wr_addr) < DEPTH);
         exp_a   = ref_read(bus.rd_addr_a, wr_taken, exp_pa);
         exp_b   = ref_read(bus.rd_addr_b, wr_taken, exp_pb);
         exp_err = (bus.wr_en && (ref_busy || int'(bus.wr_addr) >= DEPTH))
                   || int'(bus.rd_addr_a) >= DEPTH || int'(bus.rd_addr_b) >= DEPTH;
         exp_done = 1'b0;
         if (ref_busy) begin
            ref_mem[ref_pos] = '0;
            ref_inj[ref_pos] = 1'b0;
            if (ref_pos == DEPTH - 1) begin
               ref_busy = 1'b0;
               exp_done = 1'b1;
            end else begin
               ref_pos++;
            end
         end else if (bus.clr_req) begin
            ref_busy = 1'b1;
            ref_pos  = 0;
         end
         if (wr_taken) begin
            ref_mem[bus.wr_addr] = bus.wr_data;
            ref_inj[bus.wr_addr] = bus.wr_perr_inj;
         end
         exp_busy = ref_busy;
      end
      @(posedge clk);
      #1;
      chk("rd_data_a", 32'(bus.rd_data_a), 32'(exp_a));
      chk("rd_data_b", 32'(bus.rd_data_b), 32'(exp_b));
      chk("rd_perr_a", 32'(bus.rd_perr_a), 32'(exp_pa));
      chk("rd_perr_b", 32'(bus.rd_perr_b), 32'(exp_pb));
      chk("err",       32'(bus.err),       32'(exp_err));
      chk("busy",      32'(bus.busy),      32'(exp_busy));
      chk("clr_done",  32'(bus.clr_done),  32'(exp_done));
      busy_cycles += int'(bus.busy);
      done_pulses += int'(bus.clr_done);
   endtask

   task automatic scan_all();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 0, '0, 1'b0, i, DEPTH - 1 - i, 1'b0);
         step();
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1'b0;
      idle();
      step();
      step();
      rst = 1'b1;

      // Reset wipes a previously written entry.
      drive(1'b1, 3, 8'hA5, 1'b0, 0, 0, 1'b0); step();
      idle(); rst = 1'b0; step(); rst = 1'b1;
      drive(1'b0, 0, '0, 1'b0, 3, 3, 1'b0); step();
      chk("rst_entry_a", 32'(bus.rd_data_a), 32'h00);
      chk("rst_entry_b", 32'(bus.rd_data_b), 32'h00);

      // Write then read latency, and same-cycle bypass on port B.
      drive(1'b1, 5, 8'h3C, 1'b0, 0, 0, 1'b0); step();
      drive(1'b0, 0, '0, 1'b0, 5, 0, 1'b0); step();
      chk("latency_a", 32'(bus.rd_data_a), 32'h3C);
      drive(1'b1, 9, 8'h77, 1'b0, 5, 9, 1'b0); step();
      chk("bypass_b", 32'(bus.rd_data_b), 32'h77);

      // Out-of-range write and read.
      drive(1'b1, 14, 8'hFF, 1'b0, 0, 0, 1'b0); step();
      chk("oor_wr_err", 32'(bus.err), 32'h1);
      drive(1'b0, 0, '0, 1'b0, 13, 5, 1'b0); step();
      chk("oor_rd_data", 32'(bus.rd_data_a), 32'h00);
      chk("oor_rd_err", 32'(bus.err), 32'h1);
      scan_all();

      // Fill, clear, read during clear, dropped write while busy.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, i, 8'h11, 1'b0, 0, 0, 1'b0);
         step();
      end
      busy_cycles = 0;
      done_pulses = 0;
      drive(1'b0, 0, '0, 1'b0, 0, 0, 1'b1); step();
      for (int k = 0; k < DEPTH + 2; k++) begin
         drive(k == 3, 2, 8'h55, 1'b0, DEPTH - 1, k % DEPTH, 1'b0);
         step();
         if (k == 2) chk("midclear_old", 32'(bus.rd_data_a), 32'h11);
         if (k == 3) chk("busy_drop_err", 32'(bus.err), 32'h1);
      end
      chk("busy_cycles", 32'(busy_cycles), 32'(DEPTH));
      chk("done_pulses", 32'(done_pulses), 32'h1);
      scan_all();

      // Reset aborts a clear at its sixth cycle.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, i, 8'h22 + 8'(i), 1'b0, 0, 0, 1'b0);
         step();
      end
      done_pulses = 0;
      drive(1'b0, 0, '0, 1'b0, 0, 0, 1'b1); step();
      idle();
      for (int k = 0; k < 5; k++) step();
      rst = 1'b0; step(); rst = 1'b1;
      chk("abort_busy", 32'(bus.busy), 32'h0);
      for (int k = 0; k < DEPTH + 2; k++) step();
      chk("abort_no_done", 32'(done_pulses), 32'h0);
      scan_all();

      // Parity inject, then clean rewrite.
      drive(1'b1, 2, 8'h0F, 1'b1, 0, 0, 1'b0); step();
      drive(1'b0, 0, '0, 1'b0, 2, 2, 1'b0); step();
      chk("par_inj_data", 32'(bus.rd_data_a), 32'h0F);
      chk("par_inj_perr", 32'(bus.rd_perr_a), 32'(PAR));
      drive(1'b1, 2, 8'h0F, 1'b0, 0, 0, 1'b0); step();
      drive(1'b0, 0, '0, 1'b0, 2, 2, 1'b0); step();
      chk("par_clean_perr", 32'(bus.rd_perr_a), 32'h0);

      // Random traffic against the model.
      for (int n = 0; n < 500; n++) begin
         rst = ($urandom_range(0, 99) != 0);
         drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), $urandom_range(0, 29) == 0);
         step();
      end
      rst = 1'b1;
      idle();
      for (int k = 0; k < DEPTH + 1; k++) step();
      scan_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
